// File: rtl/add_round_key.sv
// add_round_key: XORs each 16-byte block of a frame with a 128-bit round key latched once per frame.
// Latency: the first output byte is valid 1 cycle after the 16th input byte; 16 bytes in, then 16 out.
// Backpressure: out_valid/out_data hold while out_ready=0; in_ready=0 while emitting or idle.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   key_load, key_in    start-of-frame strobe and round key (byte k = key_in[127-8k -: 8])
//   in_valid/in_ready   upstream byte handshake, in_data column-major within a block
//   out_valid/out_ready downstream byte handshake, out_data = buffered byte ^ key byte
//   done                sticky frame-complete flag, cleared by the next key_load
module add_round_key #(
  parameter int NUM_BLOCKS = 16384
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         done
);

  localparam int BW = $clog2(NUM_BLOCKS + 1);
  localparam logic [BW-1:0] NB = BW'(NUM_BLOCKS);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

  state_t         r_state;
  logic [127:0]   r_key;
  logic [3:0]     r_byte_cnt;
  logic [BW-1:0]  r_blk_cnt;
  logic [7:0]     r_buf [16];
  logic           r_in_ready;
  logic           r_out_valid;
  logic [7:0]     r_out_data;
  logic           r_done;

  logic [7:0]     w_key_byte [16];
  logic [3:0]     w_byte_nxt;
  logic [BW-1:0]  w_blk_inc;
  logic           w_in_fire;
  logic           w_out_fire;

  // Byte 0 of the key is the most significant byte of key_in.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_key_byte[k] = r_key[127 - 8*k -: 8];
    end
  end

  assign w_byte_nxt = r_byte_cnt + 4'd1;
  assign w_blk_inc  = r_blk_cnt + BW'(1);
  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_key       <= '0;
      r_byte_cnt  <= '0;
      r_blk_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_done      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // key_load is honoured only between frames, so the key is fixed for a whole frame.
          if (key_load) begin
            r_key      <= key_in;
            r_byte_cnt <= '0;
            r_blk_cnt  <= '0;
            r_done     <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= COLLECT;
          end
        end

        COLLECT: begin
          if (w_in_fire) begin
            r_buf[r_byte_cnt] <= in_data;
            r_byte_cnt        <= w_byte_nxt;
            if (r_byte_cnt == 4'd15) begin
              // Byte 0 was stored earlier, so the first output can be formed right now.
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= r_buf[0] ^ w_key_byte[0];
              r_byte_cnt  <= '0;
              r_state     <= EMIT;
            end
          end
        end

        EMIT: begin
          // r_byte_cnt indexes the byte currently presented on out_data.
          if (w_out_fire) begin
            r_byte_cnt <= w_byte_nxt;
            if (r_byte_cnt == 4'd15) begin
              r_out_valid <= 1'b0;
              r_blk_cnt   <= w_blk_inc;
              if (w_blk_inc == NB) begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_in_ready <= 1'b1;
                r_state    <= COLLECT;
              end
            end else begin
              r_out_data <= r_buf[w_byte_nxt] ^ w_key_byte[w_byte_nxt];
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = r_done;

endmodule
